// File: rtl/instr_stream_encoder.sv
// Packs field-level RV32I/CUSTOM0 instruction descriptors into 32-bit words and
// streams them to consecutive instruction-memory addresses behind one output register.
module instr_stream_encoder #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [3:0]       desc_class,
    input  logic [2:0]       desc_funct3,
    input  logic             desc_alt,
    input  logic [4:0]       desc_rd,
    input  logic [4:0]       desc_rs1,
    input  logic [4:0]       desc_rs2,
    input  logic [31:0]      desc_imm,
    input  logic             desc_last,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    input  logic             imem_ready,
    output logic             busy,
    output logic             done,
    output logic             full,
    output logic             err,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [31:0]  NOP     = 32'h0000_0013;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t           state, state_next;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [31:0]      addr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full_q;
    logic             err_q;

    logic             write_fire;
    logic             accept;
    logic [CNT_W:0]   committed;
    logic [6:0]       funct7;
    logic [31:0]      enc_word;
    logic             enc_bad;
    logic [31:0]      final_word;

    // Words already written plus the one sitting in the output register.
    assign committed  = {1'b0, count_q} + (CNT_W+1)'(out_valid);
    assign write_fire = out_valid & imem_ready;
    assign desc_ready = (state == S_RUN) && (!out_valid || imem_ready) && (committed < DEPTH_C);
    assign accept     = desc_valid & desc_ready;

    assign imem_we    = out_valid;
    assign imem_addr  = addr_ptr;
    assign imem_wdata = out_data;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign full       = full_q;
    assign err        = err_q;
    assign word_count = count_q;

    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        funct7   = desc_alt ? 7'b0100000 : 7'b0000000;
        case (desc_class)
            4'd0: begin
                enc_word = {funct7, desc_rs2, desc_rs1, desc_funct3, desc_rd, 7'h33};
                if (desc_alt && desc_funct3 != 3'b000 && desc_funct3 != 3'b101) enc_bad = 1'b1;
            end
            4'd1: begin
                if (desc_funct3 == 3'b001 || desc_funct3 == 3'b101)
                    enc_word = {funct7, desc_imm[4:0], desc_rs1, desc_funct3, desc_rd, 7'h13};
                else
                    enc_word = {desc_imm[11:0], desc_rs1, desc_funct3, desc_rd, 7'h13};
                if (desc_alt && desc_funct3 != 3'b101) enc_bad = 1'b1;
            end
            4'd2: begin
                enc_word = {desc_imm[11:0], desc_rs1, desc_funct3, desc_rd, 7'h03};
                if (desc_funct3 == 3'b011 || desc_funct3 == 3'b110 || desc_funct3 == 3'b111)
                    enc_bad = 1'b1;
            end
            4'd3: begin
                enc_word = {desc_imm[11:5], desc_rs2, desc_rs1, desc_funct3, desc_imm[4:0], 7'h23};
                if (desc_funct3 > 3'b010) enc_bad = 1'b1;
            end
            4'd4: begin
                enc_word = {desc_imm[12], desc_imm[10:5], desc_rs2, desc_rs1, desc_funct3,
                            desc_imm[4:1], desc_imm[11], 7'h63};
                if (desc_funct3 == 3'b010 || desc_funct3 == 3'b011 || desc_imm[0]) enc_bad = 1'b1;
            end
            4'd5: enc_word = {desc_imm[31:12], desc_rd, 7'h37};
            4'd6: enc_word = {desc_imm[31:12], desc_rd, 7'h17};
            4'd7: begin
                enc_word = {desc_imm[20], desc_imm[10:1], desc_imm[11], desc_imm[19:12], desc_rd, 7'h6F};
                if (desc_imm[0]) enc_bad = 1'b1;
            end
            4'd8: enc_word = {desc_imm[11:0], desc_rs1, 3'b000, desc_rd, 7'h67};
            4'd9: enc_word = desc_alt ? 32'h0010_0073 : 32'h0000_0073;
            4'd10: begin
                enc_word = {7'b0000000, desc_rs2, desc_rs1, desc_funct3, desc_rd, 7'h0B};
                if (desc_funct3 > 3'b001) enc_bad = 1'b1;
            end
            default: enc_bad = 1'b1;
        endcase
    end

    assign final_word = enc_bad ? NOP : enc_word;

    // Run ends on an accepted last descriptor or when the accept fills the last slot.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (accept && (desc_last || (committed + 1'b1) == DEPTH_C)) state_next = S_FLUSH;
            S_FLUSH: if (!out_valid) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            addr_ptr  <= 32'h0;
            count_q   <= '0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;

            if (state == S_IDLE && start) begin
                addr_ptr <= base_addr & ~32'h3;
                count_q  <= '0;
                full_q   <= 1'b0;
                err_q    <= 1'b0;
            end else if (write_fire) begin
                addr_ptr <= addr_ptr + 32'd4;
                count_q  <= count_q + CNT_W'(1);
                if (({1'b0, count_q} + 1'b1) == DEPTH_C) full_q <= 1'b1;
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= final_word;
                if (enc_bad) err_q <= 1'b1;
            end else if (write_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder (built with DEPTH=4 so the capacity
// limit is reachable); a negedge monitor records every completed imem write.
module tb_instr_stream_encoder;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      base_addr = 32'h0;
    logic             desc_valid = 1'b0;
    logic             desc_ready;
    logic [3:0]       desc_class = 4'd0;
    logic [2:0]       desc_funct3 = 3'd0;
    logic             desc_alt = 1'b0;
    logic [4:0]       desc_rd = 5'd0;
    logic [4:0]       desc_rs1 = 5'd0;
    logic [4:0]       desc_rs2 = 5'd0;
    logic [31:0]      desc_imm = 32'h0;
    logic             desc_last = 1'b0;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             imem_ready = 1'b1;
    logic             busy;
    logic             done;
    logic             full;
    logic             err;
    logic [CNT_W-1:0] word_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    instr_stream_encoder #(.DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_class(desc_class),
        .desc_funct3(desc_funct3), .desc_alt(desc_alt), .desc_rd(desc_rd),
        .desc_rs1(desc_rs1), .desc_rs2(desc_rs2), .desc_imm(desc_imm),
        .desc_last(desc_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy), .done(done),
        .full(full), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic do_start(input logic [31:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        bit ok = 0;
        desc_class = cls; desc_funct3 = f3; desc_alt = alt;
        desc_rd = rd; desc_rs1 = rs1; desc_rs2 = rs2; desc_imm = imm; desc_last = last;
        desc_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (desc_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        desc_valid = 1'b0;
        desc_last = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL accept_timeout got=no_ready exp=ready class=%0d", cls);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL %s_done got=0 exp=1", name);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_done_pulse got=%b exp=0", name, done);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({imem_we, busy, done, full, err, desc_ready} !== 6'b0 || word_count !== '0 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=we%b busy%b done%b full%b err%b rdy%b cnt%0d addr%h data%h exp=all_zero",
                     imem_we, busy, done, full, err, desc_ready, word_count, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || desc_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset got=busy%b rdy%b exp=0", busy, desc_ready);
        end
    endtask

    task automatic test_single();
        do_start(32'h100);
        send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1);
        checks++;
        if (imem_we !== 1'b1 || imem_wdata !== 32'h002081B3 || imem_addr !== 32'h100) begin
            failures++;
            $display("[TB] FAIL single_latency got=we%b %h@%h exp=we1 002081b3@00000100",
                     imem_we, imem_wdata, imem_addr);
        end
        wait_done("single");
        checks++;
        if (wr_data_q.size() != 1 || word_count !== 3'd1 || err !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_summary got=writes%0d cnt%0d err%b full%b exp=1 1 0 0",
                     wr_data_q.size(), word_count, err, full);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_d [4] = '{32'hFFF00293, 32'h0020A423, 32'hFE208EE3, 32'h008000EF};
        do_start(32'h0);
        send(4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        send(4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
        send(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        wait_done("stream");
        checks++;
        if (wr_data_q.size() != 4) begin
            failures++;
            $display("[TB] FAIL stream_count got=%0d exp=4", wr_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_data_q[i] !== exp_d[i] || wr_addr_q[i] !== 32'(i * 4)) begin
                    failures++;
                    $display("[TB] FAIL stream_word%0d got=%h@%h exp=%h@%h",
                             i, wr_data_q[i], wr_addr_q[i], exp_d[i], 32'(i * 4));
                end
            end
        end
        checks++;
        if (word_count !== 3'd4 || full !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_summary got=cnt%0d full%b err%b exp=4 1 0", word_count, full, err);
        end
    endtask

    task automatic test_custom0();
        logic [31:0] exp_d [3] = '{32'h0020818B, 32'h0020918B, 32'h00000013};
        do_start(32'h203);
        send(4'd10, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
        send(4'd10, 3'd1, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL custom0_err_early got=%b exp=0", err);
        end
        send(4'd10, 3'd2, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1);
        wait_done("custom0");
        checks++;
        if (wr_data_q.size() != 3) begin
            failures++;
            $display("[TB] FAIL custom0_count got=%0d exp=3", wr_data_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_data_q[i] !== exp_d[i] || wr_addr_q[i] !== 32'h200 + 32'(i * 4)) begin
                    failures++;
                    $display("[TB] FAIL custom0_word%0d got=%h@%h exp=%h@%h",
                             i, wr_data_q[i], wr_addr_q[i], exp_d[i], 32'h200 + 32'(i * 4));
                end
            end
        end
        checks++;
        if (err !== 1'b1 || word_count !== 3'd3) begin
            failures++;
            $display("[TB] FAIL custom0_summary got=err%b cnt%0d exp=1 3", err, word_count);
        end
    endtask

    task automatic test_invalid();
        logic [31:0] exp_d [4] = '{32'h0040A283, 32'h00000013, 32'h00000013, 32'h00000013};
        do_start(32'h400);
        send(4'd2, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0, 32'd4, 1'b0);
        send(4'd2, 3'd3, 1'b0, 5'd5, 5'd1, 5'd0, 32'd4, 1'b0);
        send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0);
        send(4'd13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);
        wait_done("invalid");
        checks++;
        if (wr_data_q.size() != 4) begin
            failures++;
            $display("[TB] FAIL invalid_count got=%0d exp=4", wr_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_data_q[i] !== exp_d[i]) begin
                    failures++;
                    $display("[TB] FAIL invalid_word%0d got=%h exp=%h", i, wr_data_q[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (err !== 1'b1 || word_count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL invalid_summary got=err%b cnt%0d exp=1 4", err, word_count);
        end
    endtask

    task automatic test_misc_formats();
        logic [31:0] exp_d [4] = '{32'h123453B7, 32'h40335293, 32'h00100073, 32'h004280E7};
        do_start(32'h600);
        send(4'd5, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000, 1'b0);
        send(4'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0);
        send(4'd9, 3'd0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        send(4'd8, 3'd3, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4, 1'b1);
        wait_done("misc");
        checks++;
        if (wr_data_q.size() != 4) begin
            failures++;
            $display("[TB] FAIL misc_count got=%0d exp=4", wr_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_data_q[i] !== exp_d[i]) begin
                    failures++;
                    $display("[TB] FAIL misc_word%0d got=%h exp=%h", i, wr_data_q[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL misc_err got=%b exp=0", err);
        end
    endtask

    task automatic test_stall();
        do_start(32'h40);
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== 32'h40 || imem_wdata !== 32'h00500093 || desc_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d got=we%b %h@%h rdy%b exp=we1 00500093@00000040 rdy0",
                         i, imem_we, imem_wdata, imem_addr, desc_ready);
            end
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
        send(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1);
        wait_done("stall");
        checks++;
        if (wr_data_q.size() != 2 || word_count !== 3'd2) begin
            failures++;
            $display("[TB] FAIL stall_count got=writes%0d cnt%0d exp=2 2", wr_data_q.size(), word_count);
        end else begin
            checks++;
            if (wr_data_q[0] !== 32'h00500093 || wr_addr_q[0] !== 32'h40 ||
                wr_data_q[1] !== 32'h402081B3 || wr_addr_q[1] !== 32'h44) begin
                failures++;
                $display("[TB] FAIL stall_words got=%h@%h %h@%h exp=00500093@00000040 402081b3@00000044",
                         wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1]);
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_d [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        bit extra_ready = 0;
        bit saw_done = 0;
        do_start(32'h300);
        for (int i = 1; i <= 4; i++)
            send(4'd1, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0);
        for (int k = 0; k < 2; k++) begin
            desc_class = 4'd1; desc_funct3 = 3'd0; desc_alt = 1'b0; desc_rd = 5'd9;
            desc_rs1 = 5'd0; desc_imm = 32'd9; desc_last = 1'b0; desc_valid = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (desc_ready) extra_ready = 1;
                if (done) saw_done = 1;
            end
        end
        desc_valid = 1'b0;
        checks++;
        if (extra_ready || !saw_done) begin
            failures++;
            $display("[TB] FAIL full_handshake got=ready%b done%b exp=ready0 done1", extra_ready, saw_done);
        end
        checks++;
        if (wr_data_q.size() != 4 || word_count !== 3'd4 || full !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_summary got=writes%0d cnt%0d full%b busy%b exp=4 4 1 0",
                     wr_data_q.size(), word_count, full, busy);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_data_q[i] !== exp_d[i] || wr_addr_q[i] !== 32'h300 + 32'(i * 4)) begin
                    failures++;
                    $display("[TB] FAIL full_word%0d got=%h@%h exp=%h@%h",
                             i, wr_data_q[i], wr_addr_q[i], exp_d[i], 32'h300 + 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_start(32'h80);
        imem_ready = 1'b0;
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        checks++;
        if (imem_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midflight_pending got=%b exp=1", imem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_we, busy, done, full, err, desc_ready} !== 6'b0 || word_count !== '0 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midflight_reset got=we%b busy%b cnt%0d addr%h data%h exp=all_zero",
                     imem_we, busy, word_count, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        do_start(32'h500);
        send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1);
        wait_done("resume");
        checks++;
        if (wr_data_q.size() != 1 || word_count !== 3'd1) begin
            failures++;
            $display("[TB] FAIL resume_count got=writes%0d cnt%0d exp=1 1", wr_data_q.size(), word_count);
        end else begin
            checks++;
            if (wr_addr_q[0] !== 32'h500 || wr_data_q[0] !== 32'h002081B3) begin
                failures++;
                $display("[TB] FAIL resume_word got=%h@%h exp=002081b3@00000500", wr_data_q[0], wr_addr_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_custom0();
        test_invalid();
        test_misc_formats();
        test_stall();
        test_full();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
